// File: rtl/pll_lock_mon_pkg.sv
// ============================================================================
// Module   : pll_lock_mon_pkg
// Purpose  : Shared state encoding and width constants for the PLL lock monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_lock_mon_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        LOCKED    = 3'd3,
        FAIL      = 3'd4
    } state_t;

    // Counter sized for the default LOCK_TIMEOUT (4096) plus one bit of headroom.
    localparam int c_CNT_W   = $clog2(4096) + 1;
    localparam int c_RETRY_W = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_mon_sync2.sv
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop synchronizer bringing the raw PLL lock into clk domain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/pll_lock_mon.sv
// ============================================================================
// Module   : pll_lock_mon
// Purpose  : PLL reset sequencer with lock qualification, drop filter and retry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_mon
    import pll_lock_mon_pkg::*;
#(
    parameter int CLK_PERIOD    = 20,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 256,
    parameter int DROP_CYCLES   = 4,
    parameter int MAX_RETRY     = 7
) (
    input  logic                 init_clk,
    input  logic                 i_rst,
    input  logic                 pll_lock,
    input  logic                 i_rearm,
    output logic                 pll_rst,
    output logic                 o_lock,
    output logic                 sys_rst,
    output logic [c_RETRY_W-1:0] retry_cnt,
    output logic                 fail
);

    localparam int c_MAX_CYC = max_int(max_int(RST_CYCLES, LOCK_TIMEOUT), STABLE_CYCLES);
    localparam int CW        = max_int(c_CNT_W, $clog2(c_MAX_CYC + 1));
    localparam int DW        = max_int(3, $clog2(DROP_CYCLES + 1));

    localparam logic [CW-1:0]        c_RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0]        c_TO_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0]        c_STB_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [DW-1:0]        c_DROP_LAST = DW'(DROP_CYCLES - 1);
    localparam logic [c_RETRY_W-1:0] c_MAX_RTY   = c_RETRY_W'(MAX_RETRY);

    if ((CLK_PERIOD < 1) || (MAX_RETRY < 1) || (MAX_RETRY > 15)) begin : g_param_check
        $error("pll_lock_mon: CLK_PERIOD must be >= 1 and MAX_RETRY within 1..15");
    end

    logic                 w_lock_s;
    state_t               r_state;
    state_t               w_nxt_state;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_nxt_cnt;
    logic [DW-1:0]        r_drop;
    logic [DW-1:0]        w_nxt_drop;
    logic [c_RETRY_W-1:0] r_retry;
    logic [c_RETRY_W-1:0] w_nxt_retry;
    logic [c_RETRY_W-1:0] w_retry_inc;
    logic                 r_pll_rst;
    logic                 r_lock;
    logic                 r_sys_rst;
    logic                 r_fail;

    sync2 u_sync2 (
        .clk (init_clk),
        .rst (i_rst),
        .i_d (pll_lock),
        .o_q (w_lock_s)
    );

    assign w_retry_inc = (r_retry == {c_RETRY_W{1'b1}}) ? r_retry : r_retry + 1'b1;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_drop  = r_drop;
        w_nxt_retry = r_retry;
        if (i_rearm) begin
            w_nxt_state = RESET_PLL;
            w_nxt_cnt   = '0;
            w_nxt_drop  = '0;
            w_nxt_retry = '0;
        end else begin
            case (r_state)
                RESET_PLL: begin
                    if (r_cnt == c_RST_LAST) begin
                        w_nxt_state = WAIT_LOCK;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock is checked first so a coincident timeout is not counted.
                    if (w_lock_s) begin
                        w_nxt_state = STABLE;
                        w_nxt_cnt   = '0;
                    end else if (r_cnt == c_TO_LAST) begin
                        w_nxt_retry = w_retry_inc;
                        w_nxt_state = (w_retry_inc == c_MAX_RTY) ? FAIL : RESET_PLL;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!w_lock_s) begin
                        w_nxt_state = WAIT_LOCK;
                        w_nxt_cnt   = '0;
                    end else if (r_cnt == c_STB_LAST) begin
                        w_nxt_state = LOCKED;
                        w_nxt_cnt   = '0;
                        w_nxt_drop  = '0;
                        w_nxt_retry = '0;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (w_lock_s) begin
                        w_nxt_drop = '0;
                    end else if (r_drop == c_DROP_LAST) begin
                        w_nxt_state = RESET_PLL;
                        w_nxt_cnt   = '0;
                        w_nxt_drop  = '0;
                    end else begin
                        w_nxt_drop = r_drop + 1'b1;
                    end
                end
                FAIL: begin
                    w_nxt_state = FAIL;
                end
                default: begin
                    w_nxt_state = RESET_PLL;
                    w_nxt_cnt   = '0;
                    w_nxt_drop  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge init_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RESET_PLL;
            r_cnt   <= '0;
            r_drop  <= '0;
            r_retry <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_drop  <= w_nxt_drop;
            r_retry <= w_nxt_retry;
        end
    end

    // Outputs are decoded from the next state so they change on the entry edge.
    always_ff @(posedge init_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pll_rst <= 1'b1;
            r_lock    <= 1'b0;
            r_sys_rst <= 1'b1;
            r_fail    <= 1'b0;
        end else begin
            r_pll_rst <= (w_nxt_state == RESET_PLL) || (w_nxt_state == FAIL);
            r_lock    <= (w_nxt_state == LOCKED);
            r_sys_rst <= (w_nxt_state != LOCKED);
            r_fail    <= (w_nxt_state == FAIL);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign o_lock    = r_lock;
    assign sys_rst   = r_sys_rst;
    assign retry_cnt = r_retry;
    assign fail      = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_mon.sv
// ============================================================================
// Module   : tb_pll_lock_mon
// Purpose  : Directed self-checking bench for pll_lock_mon at default parameters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_mon;

    logic       clk;
    logic       rst;
    logic       lock_in;
    logic       rearm;
    logic       pll_rst;
    logic       o_lock;
    logic       sys_rst;
    logic [3:0] retry_cnt;
    logic       fail;

    int n_checks = 0;
    int n_fail   = 0;
    int n;
    logic [3:0] r0;

    pll_lock_mon u_dut (
        .init_clk  (clk),
        .i_rst     (rst),
        .pll_lock  (lock_in),
        .i_rearm   (rearm),
        .pll_rst   (pll_rst),
        .o_lock    (o_lock),
        .sys_rst   (sys_rst),
        .retry_cnt (retry_cnt),
        .fail      (fail)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        lock_in = 1'b0;
        rearm   = 1'b0;
        #5;
        check("rst_pll_rst", pll_rst, 1);
        check("rst_o_lock", o_lock, 0);
        check("rst_sys_rst", sys_rst, 1);
        check("rst_retry", retry_cnt, 0);
        check("rst_fail", fail, 0);
        repeat (3) tick();

        // Clean lock
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
        check("rst_pulse_len", n, 16);
        repeat (100) tick();
        check("wait_retry", retry_cnt, 0);
        check("wait_no_lock", o_lock, 0);
        lock_in = 1'b1;
        n = 0;
        while (o_lock !== 1'b1 && n < 400) begin tick(); n++; end
        check("lock_latency_in_window", (n >= 257 && n <= 259), 1);
        check("locked_sys_rst", sys_rst, 0);
        check("locked_pll_rst", pll_rst, 0);
        check("locked_retry", retry_cnt, 0);

        // Short glitch is filtered
        lock_in = 1'b0;
        repeat (3) tick();
        lock_in = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_lock !== 1'b1) n++;
        end
        check("glitch3_lows", n, 0);

        // Long drop: 2 sync cycles + 4 drop cycles
        lock_in = 1'b0;
        n = 0;
        while (o_lock === 1'b1 && n < 20) begin tick(); n++; end
        check("drop_latency", n, 6);
        check("drop_sys_rst", sys_rst, 1);
        check("drop_pll_rst", pll_rst, 1);
        lock_in = 1'b1;
        n = 0;
        while (pll_rst === 1'b1 && n < 40) begin tick(); n++; end
        check("drop_rst_pulse_len", n, 16);
        n = 0;
        while (o_lock !== 1'b1 && n < 400) begin tick(); n++; end
        check("relock_latency", n, 257);

        // Rearm from LOCKED, then a 1-cycle dropout during STABLE
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        check("rearm_o_lock", o_lock, 0);
        check("rearm_pll_rst", pll_rst, 1);
        n = 0;
        while (pll_rst === 1'b1 && n < 40) begin tick(); n++; end
        check("rearm_rst_pulse_len", n, 16);
        repeat (200) tick();
        lock_in = 1'b0;
        tick();
        lock_in = 1'b1;
        n = 1;
        while (o_lock !== 1'b1 && n < 600) begin tick(); n++; end
        check("unstable_relock_latency", n, 260);

        // Asynchronous reset while LOCKED
        @(posedge clk);
        #5 rst = 1'b1;
        #1;
        check("async_o_lock", o_lock, 0);
        check("async_sys_rst", sys_rst, 1);
        check("async_pll_rst", pll_rst, 1);
        lock_in = 1'b0;

        // One timeout, then lock arriving on the exact timeout cycle
        @(negedge clk);
        rst = 1'b0;
        repeat (4112) tick();
        check("first_timeout_retry", retry_cnt, 1);
        check("first_timeout_pll_rst", pll_rst, 1);
        repeat (4109) tick();
        lock_in = 1'b1;
        repeat (3) tick();
        check("race_retry_kept", retry_cnt, 1);
        check("race_goes_stable", pll_rst, 0);
        repeat (255) tick();
        check("race_not_yet_locked", o_lock, 0);
        tick();
        check("race_locked", o_lock, 1);
        check("locked_clears_retry", retry_cnt, 0);

        // Timeouts up to FAIL
        #3 rst = 1'b1;
        lock_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            r0 = retry_cnt;
            n = 0;
            while (retry_cnt === r0 && n < 5000) begin tick(); n++; end
            check("timeout_interval", n, 4112);
            check("timeout_retry", retry_cnt, k);
            check("timeout_fail_flag", fail, (k == 7));
        end
        check("fail_pll_rst", pll_rst, 1);
        check("fail_o_lock", o_lock, 0);
        check("fail_sys_rst", sys_rst, 1);
        lock_in = 1'b1;
        repeat (600) tick();
        check("fail_sticky", fail, 1);
        check("fail_retry_held", retry_cnt, 7);
        check("fail_pll_rst_held", pll_rst, 1);
        check("fail_no_lock", o_lock, 0);

        // Rearm out of FAIL
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        check("rearm_fail_clr", fail, 0);
        check("rearm_retry_clr", retry_cnt, 0);
        check("rearm_fail_pll_rst", pll_rst, 1);
        n = 0;
        while (pll_rst === 1'b1 && n < 40) begin tick(); n++; end
        check("rearm_fail_rst_len", n, 16);
        n = 0;
        while (o_lock !== 1'b1 && n < 400) begin tick(); n++; end
        check("rearm_fail_lock_latency", n, 257);
        check("rearm_fail_sys_rst", sys_rst, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
